// File: rtl/l1_l2_port_arbiter_if.sv
// Bundle of every L1-side and L2-side signal of the L1->L2 port arbiter.
// The arbiter connects through the slave modport. The L1 caches plus the L2
// (or a bench standing in for them) connect through the master modport.
// fsm_state and rr_ptr are observation-only outputs for checkers.
interface l1_l2_port_arbiter_if #(
  parameter int NUM_PORTS     = 4,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int LINE_WIDTH    = 128
);
  localparam int ID_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  // L1 side requests
  logic [NUM_PORTS-1:0]               l1_read_req;
  logic [NUM_PORTS-1:0]               l1_write_req;
  logic [NUM_PORTS-1:0]               l1_write_back_req;
  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] l1_address;
  logic [NUM_PORTS*DATA_WIDTH-1:0]    l1_write_data;
  logic [NUM_PORTS*LINE_WIDTH-1:0]    l1_write_back_data;

  // L2 side completions
  logic                               L2_ready;
  logic                               write_to_L2_verified;
  logic                               write_back_to_L2_verified;
  logic [LINE_WIDTH-1:0]              read_data_from_L2;

  // L2 side requests
  logic [ADDRESS_WIDTH-1:0]           cache_L2_memory_address;
  logic                               read_from_L2_request;
  logic                               write_to_L2_request;
  logic                               write_back_to_L2_request;
  logic [DATA_WIDTH-1:0]              write_data_to_L2;
  logic [LINE_WIDTH-1:0]              write_back_to_L2_data;

  // L1 side completions and status
  logic [NUM_PORTS-1:0]               l1_L2_ready;
  logic [NUM_PORTS-1:0]               l1_write_verified;
  logic [NUM_PORTS-1:0]               l1_write_back_verified;
  logic [LINE_WIDTH-1:0]              l1_read_data;
  logic [ID_WIDTH-1:0]                grant_id;
  logic                               arbiter_busy;

  // Debug observation
  logic [1:0]                         fsm_state;
  logic [ID_WIDTH-1:0]                rr_ptr;

  modport slave (
    input  l1_read_req, l1_write_req, l1_write_back_req,
    input  l1_address, l1_write_data, l1_write_back_data,
    input  L2_ready, write_to_L2_verified, write_back_to_L2_verified,
    input  read_data_from_L2,
    output cache_L2_memory_address, read_from_L2_request,
    output write_to_L2_request, write_back_to_L2_request,
    output write_data_to_L2, write_back_to_L2_data,
    output l1_L2_ready, l1_write_verified, l1_write_back_verified,
    output l1_read_data, grant_id, arbiter_busy,
    output fsm_state, rr_ptr
  );

  modport master (
    output l1_read_req, l1_write_req, l1_write_back_req,
    output l1_address, l1_write_data, l1_write_back_data,
    output L2_ready, write_to_L2_verified, write_back_to_L2_verified,
    output read_data_from_L2,
    input  cache_L2_memory_address, read_from_L2_request,
    input  write_to_L2_request, write_back_to_L2_request,
    input  write_data_to_L2, write_back_to_L2_data,
    input  l1_L2_ready, l1_write_verified, l1_write_back_verified,
    input  l1_read_data, grant_id, arbiter_busy,
    input  fsm_state, rr_ptr
  );
endinterface

// File: rtl/l1_l2_port_arbiter.sv
// Round-robin arbiter that shares one L1->L2 request port among NUM_PORTS
// private L1 caches.
//
// Handshake: each L1 request bit is a level. It is held until the matching
// one-cycle l1_* done pulse for that port. The L2 request bit is also a level,
// with address and data held stable. It stays high until the matching L2
// completion is sampled, and it drops on the following edge.
// A completion that does not match the outstanding op is not a handshake and
// is ignored.
module l1_l2_port_arbiter #(
  parameter int NUM_PORTS     = 4,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int LINE_WIDTH    = 128
) (
  input logic clk,
  input logic reset,
  l1_l2_port_arbiter_if.slave bus
);
  localparam int IDW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RELEASE = 2'd2} state_t;
  typedef enum logic [1:0] {OP_NONE = 2'd0, OP_READ = 2'd1, OP_WRITE = 2'd2, OP_WB = 2'd3} op_t;

  state_t                   state_q, state_d;
  op_t                      op_q, op_d;
  logic [IDW-1:0]           grant_q, grant_d;
  logic [IDW-1:0]           rr_q, rr_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                     rd_req_q, rd_req_d;
  logic                     wr_req_q, wr_req_d;
  logic                     wb_req_q, wb_req_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [LINE_WIDTH-1:0]    wbdata_q, wbdata_d;
  logic [NUM_PORTS-1:0]     rd_done_q, rd_done_d;
  logic [NUM_PORTS-1:0]     wr_done_q, wr_done_d;
  logic [NUM_PORTS-1:0]     wb_done_q, wb_done_d;
  logic [LINE_WIDTH-1:0]    rdata_q, rdata_d;
  logic                     busy_q, busy_d;

  logic [NUM_PORTS-1:0]     pending;
  logic                     any_pending;
  logic [IDW-1:0]           winner;
  logic                     found;
  logic                     done;

  // Round-robin search: first pending port at or after rr_ptr, wrapping.
  always_comb begin
    pending     = bus.l1_read_req | bus.l1_write_req | bus.l1_write_back_req;
    any_pending = |pending;
    winner      = '0;
    found       = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      int idx;
      idx = int'(rr_q) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && pending[idx]) begin
        winner = IDW'(idx);
        found  = 1'b1;
      end
    end
  end

  // Only the completion belonging to the latched op can end a transaction.
  always_comb begin
    done = ((op_q == OP_READ)  && bus.L2_ready) ||
           ((op_q == OP_WRITE) && bus.write_to_L2_verified) ||
           ((op_q == OP_WB)    && bus.write_back_to_L2_verified);
  end

  // Next-state and next-output logic for IDLE / BUSY / RELEASE.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    addr_d    = addr_q;
    rd_req_d  = rd_req_q;
    wr_req_d  = wr_req_q;
    wb_req_d  = wb_req_q;
    wdata_d   = wdata_q;
    wbdata_d  = wbdata_q;
    rd_done_d = '0;
    wr_done_d = '0;
    wb_done_d = '0;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: begin
        if (any_pending) begin
          grant_d = winner;
          addr_d  = bus.l1_address[int'(winner)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          // Write-back before write before read, matching the L1 evict-then-fill order.
          if (bus.l1_write_back_req[winner]) begin
            op_d     = OP_WB;
            wb_req_d = 1'b1;
            wbdata_d = bus.l1_write_back_data[int'(winner)*LINE_WIDTH +: LINE_WIDTH];
          end else if (bus.l1_write_req[winner]) begin
            op_d     = OP_WRITE;
            wr_req_d = 1'b1;
            wdata_d  = bus.l1_write_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
          end else begin
            op_d     = OP_READ;
            rd_req_d = 1'b1;
          end
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (done) begin
          case (op_q)
            OP_READ: begin
              rd_done_d[grant_q] = 1'b1;
              rdata_d            = bus.read_data_from_L2;
            end
            OP_WRITE: wr_done_d[grant_q] = 1'b1;
            OP_WB:    wb_done_d[grant_q] = 1'b1;
            default:  ;
          endcase
          op_d     = OP_NONE;
          addr_d   = '0;
          rd_req_d = 1'b0;
          wr_req_d = 1'b0;
          wb_req_d = 1'b0;
          wdata_d  = '0;
          wbdata_d = '0;
          rr_d     = (grant_q == IDW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
          state_d  = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset drops everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= OP_NONE;
      grant_q   <= '0;
      rr_q      <= '0;
      addr_q    <= '0;
      rd_req_q  <= 1'b0;
      wr_req_q  <= 1'b0;
      wb_req_q  <= 1'b0;
      wdata_q   <= '0;
      wbdata_q  <= '0;
      rd_done_q <= '0;
      wr_done_q <= '0;
      wb_done_q <= '0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      addr_q    <= addr_d;
      rd_req_q  <= rd_req_d;
      wr_req_q  <= wr_req_d;
      wb_req_q  <= wb_req_d;
      wdata_q   <= wdata_d;
      wbdata_q  <= wbdata_d;
      rd_done_q <= rd_done_d;
      wr_done_q <= wr_done_d;
      wb_done_q <= wb_done_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.cache_L2_memory_address = addr_q;
  assign bus.read_from_L2_request    = rd_req_q;
  assign bus.write_to_L2_request     = wr_req_q;
  assign bus.write_back_to_L2_request = wb_req_q;
  assign bus.write_data_to_L2        = wdata_q;
  assign bus.write_back_to_L2_data   = wbdata_q;
  assign bus.l1_L2_ready             = rd_done_q;
  assign bus.l1_write_verified       = wr_done_q;
  assign bus.l1_write_back_verified  = wb_done_q;
  assign bus.l1_read_data            = rdata_q;
  assign bus.grant_id                = grant_q;
  assign bus.arbiter_busy            = busy_q;
  assign bus.fsm_state               = state_q;
  assign bus.rr_ptr                  = rr_q;
endmodule

// File: doc/l1_l2_port_arbiter.md
# l1_l2_port_arbiter

- Shares the single L1→L2 request port among `NUM_PORTS` private L1 caches, one per processor ID.
- Picks one pending L1 request by round-robin, drives it to L2, and holds it until L2 signals completion.
- Routes the completion pulse and any fill line back to the granted L1 only.
- Sits between the L1 cache FSMs and the L2 cache FSM, one instance per core cluster.

## Interface
- `NUM_PORTS`, 4, number of L1 requesters; port index equals processor ID.
- `ADDRESS_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, word width for write-through writes.
- `LINE_WIDTH`, 128, cache-line width for fills and write-backs.

One clock; reset is asynchronous and active-high.

- `clk`  in  1  clock; all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state and outputs
- `l1_read_req`  in  NUM_PORTS  per-port read (fill) request, level, held until served
- `l1_write_req`  in  NUM_PORTS  per-port write-through request, level
- `l1_write_back_req`  in  NUM_PORTS  per-port dirty-line write-back request, level
- `l1_address`  in  NUM_PORTS*ADDRESS_WIDTH  per-port address; port i at [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
- `l1_write_data`  in  NUM_PORTS*DATA_WIDTH  per-port write word
- `l1_write_back_data`  in  NUM_PORTS*LINE_WIDTH  per-port evicted line
- `L2_ready`  in  1  L2 read complete; `read_data_from_L2` valid
- `write_to_L2_verified`  in  1  L2 write complete
- `write_back_to_L2_verified`  in  1  L2 write-back complete
- `read_data_from_L2`  in  LINE_WIDTH  fill line
- `cache_L2_memory_address`  out  ADDRESS_WIDTH  address to L2
- `read_from_L2_request`  out  1  read request to L2
- `write_to_L2_request`  out  1  write request to L2
- `write_back_to_L2_request`  out  1  write-back request to L2
- `write_data_to_L2`  out  DATA_WIDTH  write word to L2
- `write_back_to_L2_data`  out  LINE_WIDTH  write-back line to L2
- `l1_L2_ready`  out  NUM_PORTS  one-hot, 1-cycle read-done pulse
- `l1_write_verified`  out  NUM_PORTS  one-hot, 1-cycle write-done pulse
- `l1_write_back_verified`  out  NUM_PORTS  one-hot, 1-cycle write-back-done pulse
- `l1_read_data`  out  LINE_WIDTH  last fill line, broadcast to all ports
- `grant_id`  out  $clog2(NUM_PORTS)  port currently or last granted
- `arbiter_busy`  out  1  high in BUSY and RELEASE

## Operation
- A port is pending when any of its three request bits is set.
- Priority within a port: write-back > write > read. This matches the L1 evict-then-fill order.
- Round-robin pointer `rr_ptr`, reset value 0.
  - Search order is rr_ptr, rr_ptr+1, …, wrapping modulo NUM_PORTS.
  - The first pending port wins.
  - On completion, rr_ptr ← granted+1, wrapping NUM_PORTS-1 → 0.
- FSM states are IDLE, BUSY and RELEASE. All outputs are registered.
- **IDLE**
  - If no port is pending, stay in IDLE.
  - Otherwise, on the next edge:
    - latch the winner into `grant_id` and the chosen op into an op register;
    - latch the winner's address and data into the L2 output registers;
    - assert exactly one L2 request bit;
    - go to BUSY.
- **BUSY**
  - Hold the L2 request and its address/data stable.
  - Requester inputs are ignored; a dropped request does not abort.
  - Only the completion matching the latched op ends the transaction:
    - read ← `L2_ready`;
    - write ← `write_to_L2_verified`;
    - write-back ← `write_back_to_L2_verified`.
  - Non-matching completions are ignored.
  - On a matching completion, at the next edge:
    - deassert the L2 request and clear the L2 address/data;
    - pulse the matching `l1_*` bit of `grant_id` for 1 cycle;
    - for reads, latch `read_data_from_L2` into `l1_read_data`;
    - update rr_ptr;
    - go to RELEASE.
- **RELEASE**
  - Lasts one cycle so the served L1 can drop its request; no arbitration happens.
  - Then go to IDLE.
- `l1_read_data` holds until the next read completion. It is not cleared in RELEASE.
- Completion inputs seen in IDLE or RELEASE are ignored.

## Timing
- Reset: all outputs, rr_ptr and the op register are 0; the FSM is in IDLE. Reset mid-transaction drops the L2 request immediately (async); no pulse is issued.
- Grant latency: request sampled in IDLE cycle t → L2 request high from cycle t+1.
- Completion: matching L2 signal in cycle c → L2 request low and `l1_*` pulse in cycle c+1 → IDLE in cycle c+2.
- Completion in the first BUSY cycle is legal. Minimum transaction length is 3 cycles (BUSY, RELEASE, IDLE).
- Back-to-back grants are at least 3 cycles apart. Pulses are never asserted for two ports at once.

## Test plan
- Single read, port 1:
  - Stimulus: address 0x4000_0010; L2_ready 4 cycles after request; data 0xA5…A5.
  - Response: `read_from_L2_request` high for 4 cycles; `l1_L2_ready`=4'b0010 for 1 cycle; `l1_read_data`=0xA5…A5; rr_ptr=2.
- Intra-port priority, port 2:
  - Stimulus: write-back and read raised together.
  - Response: write-back is served first with `write_back_to_L2_data` forwarded; the read is granted after RELEASE.
- Round-robin fairness:
  - Stimulus: all 4 ports hold reads; L2 answers each after 2 cycles.
  - Response: grant order 0,1,2,3,0; no port is starved; pulses are one-hot.
- Mismatched completion:
  - Stimulus: port 3 write outstanding; `L2_ready` pulses first.
  - Response: ignored, request held; `write_to_L2_verified` then ends the transaction with `l1_write_verified`=4'b1000.
- Reset mid-BUSY:
  - Stimulus: assert reset while port 0 read outstanding.
  - Response: all outputs 0 immediately, no pulse; after release, FSM in IDLE with rr_ptr=0.
- Wrap and request drop:
  - Stimulus: port 3 served; port 3 deasserts its request during BUSY.
  - Response: transaction still completes; rr_ptr wraps to 0.
